// File: rtl/seg_pkg.sv
// seg_pkg: shared segment encodings, anode patterns and conversion FSM states.
package seg_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  localparam logic [3:0] ANODE_SEL [0:3] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t;
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    return (n < 4'd10) ? SEG_DIGIT[n] : SEG_BLANK;
  endfunction
endpackage

// File: rtl/bcd_serial_converter.sv
// bcd_serial_converter: one-bit-per-cycle double-dabble, restartable by start in any state.
module bcd_serial_converter
  import seg_pkg::*;
#(
  parameter int VAL_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VAL_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             load,
  output logic [15:0]      bcd
);
  localparam int CW = $clog2(VAL_W);
  conv_state_t state_q, state_d;
  logic [VAL_W-1:0] sh_q, sh_d;
  logic [15:0] bcd_q, bcd_d, adj;
  logic [CW-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = start ? LOAD :
              state_q == LOAD ? SHIFT :
              state_q == SHIFT ? (cnt_q == CW'(VAL_W - 1) ? DONE : SHIFT) : IDLE;
  end
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++)
      adj[i*4 +: 4] = bcd_q[i*4 +: 4] >= 4'd5 ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
    sh_d = state_q == LOAD ? value : state_q == SHIFT ? sh_q << 1 : sh_q;
    bcd_d = state_q == LOAD ? '0 : state_q == SHIFT ? {adj[14:0], sh_q[VAL_W-1]} : bcd_q;
    cnt_d = state_q == SHIFT ? cnt_q + 1'b1 : '0;
  end
  always_comb begin
    busy = state_q != IDLE;
    done = state_q == DONE;
    load = state_q == LOAD;
    bcd = bcd_q;
  end
endmodule

// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: round-robin sharing of a 4-digit 7-seg display among debug sources.
// Define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits (ones digit always shown).
module seg_display_scheduler
  import seg_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int VAL_W        = 13,
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int SCAN_BITS    = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC*VAL_W-1:0]   src_val,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic                       hold,
  output logic [$clog2(NUM_SRC)-1:0] cur_src,
  output logic                       busy,
  output logic [3:0]                 Anode,
  output logic [6:0]                 LED_out
);
  localparam int SW = $clog2(NUM_SRC);
  localparam int DW = $clog2(DWELL_CYCLES + 1);
  logic [DW-1:0] dwell_q, dwell_d;
  logic [SW-1:0] src_q, src_d, nxt, idx;
  logic [VAL_W-1:0] last_q, last_d, cur_val;
  logic have_q, have_d;
  logic [15:0] dig_q, dig_d, bcd;
  logic [SCAN_BITS-1:0] scan_q, scan_d;
  logic [3:0] an_q, an_d, nib;
  logic [6:0] led_q, led_d;
  logic [1:0] sel;
  logic wrap, sw, start, cur_ok, conv_done, conv_load, lz;
  bcd_serial_converter #(.VAL_W(VAL_W)) u_conv (
    .clk(clk), .rst(rst), .start(start), .value(cur_val),
    .busy(busy), .done(conv_done), .load(conv_load), .bcd(bcd)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q <= '0;
      src_q <= '0;
      last_q <= '0;
      have_q <= 1'b0;
      dig_q <= '0;
      scan_q <= '0;
      an_q <= 4'hF;
      led_q <= SEG_BLANK;
    end else begin
      dwell_q <= dwell_d;
      src_q <= src_d;
      last_q <= last_d;
      have_q <= have_d;
      dig_q <= dig_d;
      scan_q <= scan_d;
      an_q <= an_d;
      led_q <= led_d;
    end
  end
  // Lowest offset wins: scan offsets high to low so the nearest valid source is kept last.
  always_comb begin
    nxt = src_q;
    idx = '0;
    for (int k = NUM_SRC - 1; k >= 1; k--) begin
      idx = SW'((int'(src_q) + k) % NUM_SRC);
      if (src_valid[idx]) nxt = idx;
    end
  end
  always_comb begin
    cur_val = src_val[src_q*VAL_W +: VAL_W];
    cur_ok = src_valid[src_q];
    wrap = !hold && dwell_q == DW'(DWELL_CYCLES - 1);
    sw = wrap && nxt != src_q;
    start = sw || (cur_ok && !busy && (!have_q || cur_val != last_q));
    dwell_d = hold ? dwell_q : wrap ? '0 : dwell_q + 1'b1;
    src_d = wrap ? nxt : src_q;
    last_d = conv_load ? cur_val : last_q;
    have_d = have_q | conv_load;
    dig_d = conv_done ? bcd : dig_q;
    scan_d = scan_q + 1'b1;
    sel = scan_q[SCAN_BITS-1 -: 2];
    nib = dig_q[4*(3 - int'(sel)) +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    lz = sel == 2'd0 ? dig_q[15:12] == 4'd0 :
         sel == 2'd1 ? dig_q[15:8] == 8'd0 :
         sel == 2'd2 ? dig_q[15:4] == 12'd0 : 1'b0;
`else
    lz = 1'b0;
`endif
    an_d = ANODE_SEL[sel];
    led_d = (!cur_ok || lz) ? SEG_BLANK : seg_of(nib);
    cur_src = src_q;
    Anode = an_q;
    LED_out = led_q;
  end
endmodule

// File: tb/tb_seg_display_scheduler.sv
// tb_seg_display_scheduler: randomized checks of rotation, hold, abort and digit display.
module tb_seg_display_scheduler;
  localparam int NS = 4, VW = 13, DW = 50, SB = 4;
  localparam logic [6:0] SEGS [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
  logic clk = 0, rst = 1, hold = 0;
  logic [NS*VW-1:0] src_val = '0;
  logic [NS-1:0] src_valid = '0;
  logic [1:0] cur_src;
  logic busy;
  logic [3:0] Anode;
  logic [6:0] LED_out;
  int tests = 0, fails = 0, cyc = 0, md = 0, ms = 0;
  int vals [NS] = '{0, 0, 0, 0};

  seg_display_scheduler #(.NUM_SRC(NS), .VAL_W(VW), .DWELL_CYCLES(DW), .SCAN_BITS(SB)) dut (
    .clk(clk), .rst(rst), .src_val(src_val), .src_valid(src_valid), .hold(hold),
    .cur_src(cur_src), .busy(busy), .Anode(Anode), .LED_out(LED_out)
  );

  always #5 clk = ~clk;

  function automatic int next_valid(input logic [NS-1:0] m, input int c);
    for (int k = 1; k < NS; k++) if (m[(c + k) % NS]) return (c + k) % NS;
    return c;
  endfunction

  // Reference: each DW un-held cycles, move to the next valid source.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      md <= 0;
      ms <= 0;
    end else if (!hold) begin
      if (md == DW - 1) begin
        md <= 0;
        ms <= next_valid(src_valid, ms);
      end else md <= md + 1;
    end
  end

  function automatic logic [6:0] exp_seg(input int v, input int p);
    int pw;
    pw = (p == 0) ? 1000 : (p == 1) ? 100 : (p == 2) ? 10 : 1;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (p < 3 && v < pw) return 7'h7F;
`endif
    return SEGS[(v / pw) % 10];
  endfunction

  task automatic set_val(input int i, input int v);
    vals[i] = v;
    src_val[i*VW +: VW] = VW'(v);
  endtask

  task automatic wait_idle(input string nm);
    int z, n;
    z = 0;
    n = 0;
    while (z < 2 && n < 100) begin
      @(negedge clk);
      n++;
      z = busy ? 0 : z + 1;
    end
    tests++;
    if (z < 2) begin
      fails++;
      $display("FAIL %s idle_wait: busy=%b still after %0d cycles", nm, busy, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_disp(input int v, input bit ok, input string nm);
    logic [6:0] got [4];
    logic [6:0] exp;
    bit bad;
    bad = 0;
    for (int p = 0; p < 4; p++) got[p] = 'x;
    repeat (16) begin
      @(negedge clk);
      case (Anode)
        4'b0111: got[0] = LED_out;
        4'b1011: got[1] = LED_out;
        4'b1101: got[2] = LED_out;
        4'b1110: got[3] = LED_out;
        default: bad = 1;
      endcase
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL %s anode: a non one-cold Anode pattern appeared, last=%b", nm, Anode);
    end
    for (int p = 0; p < 4; p++) begin
      exp = ok ? exp_seg(v, p) : 7'h7F;
      tests++;
      if (got[p] !== exp) begin
        fails++;
        $display("FAIL %s digit%0d: LED_out=%b expected %b (value %0d)", nm, p, got[p], exp, v);
      end
    end
  endtask

  task automatic wait_change(input string nm, input int lim, output int n);
    logic [1:0] s;
    s = cur_src;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cur_src == s && n < lim);
    tests++;
    if (cur_src == s) begin
      fails++;
      $display("FAIL %s: cur_src stuck at %0d after %0d cycles", nm, cur_src, n);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    tests += 4;
    if (Anode !== 4'hF) begin fails++; $display("FAIL reset_anode: %b expected 1111", Anode); end
    if (LED_out !== 7'h7F) begin fails++; $display("FAIL reset_led: %b expected 1111111", LED_out); end
    if (cur_src !== 2'd0) begin fails++; $display("FAIL reset_src: %0d expected 0", cur_src); end
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: %b expected 0", busy); end
    rst = 0;
  endtask

  task automatic test_single;
    int n, b;
    src_valid = 4'b0001;
    set_val(0, 1234);
    n = 0;
    while (!busy && n < 5) begin @(negedge clk); n++; end
    b = 0;
    while (busy && b < 40) begin @(negedge clk); b++; end
    tests++;
    if (b !== VW + 2) begin fails++; $display("FAIL single_busy_len: %0d cycles expected %0d", b, VW + 2); end
    repeat (2) @(negedge clk);
    check_disp(1234, 1, "single");
    tests++;
    if (cur_src !== 2'd0) begin fails++; $display("FAIL single_src: %0d expected 0", cur_src); end
  endtask

  task automatic test_leading;
    int tv [2] = '{42, 0};
    for (int i = 0; i < 2; i++) begin
      set_val(0, tv[i]);
      wait_idle("leading");
      check_disp(tv[i], 1, "leading");
    end
  endtask

  task automatic test_invalid;
    int bz;
    src_valid = 4'b0000;
    set_val(0, int'($urandom_range(1, 8191)));
    bz = 0;
    repeat (20) begin @(negedge clk); if (busy) bz++; end
    tests++;
    if (bz != 0) begin fails++; $display("FAIL invalid_busy: busy for %0d cycles expected 0", bz); end
    check_disp(0, 0, "invalid");
  endtask

  task automatic test_rotate;
    int n, t, tp, prev, e;
    src_valid = 4'b1011;
    set_val(0, 7);
    set_val(1, 8191);
    set_val(2, int'($urandom_range(0, 8191)));
    set_val(3, 42);
    prev = cur_src;
    tp = 0;
    for (int i = 0; i < 4; i++) begin
      wait_change("rotate", 60, n);
      t = cyc;
      e = next_valid(src_valid, prev);
      tests += 2;
      if (cur_src !== 2'(e)) begin fails++; $display("FAIL rotate_next: cur_src=%0d expected %0d", cur_src, e); end
      if (int'(cur_src) != ms) begin fails++; $display("FAIL rotate_model: cur_src=%0d expected %0d", cur_src, ms); end
      if (i > 0) begin
        tests++;
        if (t - tp != DW) begin fails++; $display("FAIL rotate_period: %0d cycles expected %0d", t - tp, DW); end
      end
      tp = t;
      prev = cur_src;
      wait_idle("rotate");
      check_disp(vals[cur_src], 1, "rotate");
    end
  endtask

  task automatic test_hold;
    int n, ch;
    logic [1:0] s;
    wait_change("hold_sync", 60, n);
    repeat (10) @(negedge clk);
    hold = 1;
    s = cur_src;
    ch = 0;
    repeat (200) begin @(negedge clk); if (cur_src !== s) ch++; end
    tests++;
    if (ch != 0) begin fails++; $display("FAIL hold_frozen: cur_src moved in %0d cycles expected 0", ch); end
    hold = 0;
    wait_change("hold_release", 100, n);
    tests++;
    if (n != DW - 10) begin fails++; $display("FAIL hold_remaining: rotated after %0d cycles expected %0d", n, DW - 10); end
  endtask

  task automatic test_abort;
    int n, b, s, o;
    src_valid = 4'b0011;
    set_val(0, int'($urandom_range(0, 4000)));
    set_val(1, int'($urandom_range(4001, 8191)));
    wait_change("abort_sync", 60, n);
    s = cur_src;
    o = next_valid(src_valid, s);
    repeat (43) @(negedge clk);
    set_val(s, (vals[s] + 1 + int'($urandom_range(0, 100))) % 8192);
    repeat (7) @(negedge clk);
    tests += 2;
    if (cur_src !== 2'(o)) begin fails++; $display("FAIL abort_switch: cur_src=%0d expected %0d", cur_src, o); end
    if (busy !== 1'b1) begin fails++; $display("FAIL abort_in_shift: busy=%b expected 1", busy); end
    b = 0;
    while (busy && b < 40) begin @(negedge clk); b++; end
    tests++;
    if (b != VW + 2) begin fails++; $display("FAIL abort_latency: %0d cycles expected %0d", b, VW + 2); end
    repeat (2) @(negedge clk);
    check_disp(vals[o], 1, "abort");
  endtask

  task automatic test_back_to_back;
    int n, c, a, bv;
    hold = 1;
    wait_idle("b2b_pre");
    c = cur_src;
    a = (vals[c] + 1 + int'($urandom_range(0, 3000))) % 8192;
    bv = (a + 1 + int'($urandom_range(0, 3000))) % 8192;
    set_val(c, a);
    repeat (6) @(negedge clk);
    set_val(c, bv);
    n = 0;
    while (busy && n < 40) begin @(negedge clk); n++; end
    tests++;
    if (n != 10) begin fails++; $display("FAIL b2b_first_finish: %0d cycles expected 10", n); end
    @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL b2b_retrigger: busy=%b expected 1", busy); end
    wait_idle("b2b");
    check_disp(bv, 1, "b2b");
    hold = 0;
  endtask

  task automatic test_random;
    int n;
    for (int r = 0; r < 6; r++) begin
      n = 0;
      while (md != DW - 1 && n < 60) begin @(negedge clk); n++; end
      src_valid = 4'($urandom_range(1, 15));
      for (int i = 0; i < NS; i++) set_val(i, int'($urandom_range(0, 8191)));
      wait_idle("random");
      tests++;
      if (int'(cur_src) != ms) begin fails++; $display("FAIL random_src: cur_src=%0d expected %0d", cur_src, ms); end
      check_disp(vals[ms], 1, "random");
    end
  endtask

  task automatic test_rst_mid;
    int v;
    set_val(cur_src, (vals[cur_src] + 1) % 8192);
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    tests += 4;
    if (Anode !== 4'hF) begin fails++; $display("FAIL rstmid_anode: %b expected 1111", Anode); end
    if (LED_out !== 7'h7F) begin fails++; $display("FAIL rstmid_led: %b expected 1111111", LED_out); end
    if (cur_src !== 2'd0) begin fails++; $display("FAIL rstmid_src: %0d expected 0", cur_src); end
    if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: %b expected 0", busy); end
    src_valid = 4'b0001;
    v = int'($urandom_range(0, 8191));
    set_val(0, v);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_restart: busy=%b expected 1", busy); end
    wait_idle("rstmid");
    check_disp(v, 1, "rstmid");
  endtask

  initial begin
    test_reset;
    test_single;
    test_leading;
    test_invalid;
    test_rotate;
    test_hold;
    test_abort;
    test_back_to_back;
    test_random;
    test_rst_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish in time");
    $fatal(1);
  end
endmodule
